// File: rtl/rank_pkg.sv
// Shared types and helpers for the frame ranking scheduler.
package rank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/max2_track.sv
// Running largest / second-largest tracker; duplicates rank separately.
module max2_track
  #(parameter int unsigned DATA_WIDTH = 32)
  (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] max,
    output logic [DATA_WIDTH-1:0] second
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max    <= '0;
      second <= '0;
    end else if (clr) begin
      max    <= '0;
      second <= '0;
    end else if (load) begin
      max    <= din;
      second <= '0;
    end else if (en) begin
      if (din > max) begin
        second <= max;
        max    <= din;
      end else if (din > second) begin
        second <= din;
      end
    end
  end

endmodule

// File: rtl/rank_frame_sched.sv
// Frame scheduler: ranks the first MAX_LEN samples of each frame and reports
// max/second/count with short and overflow flags through a valid/ready port.
module rank_frame_sched
  import rank_pkg::*;
  #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_LEN    = 16,
    localparam int unsigned CW         = clog2(MAX_LEN + 1)
  )
  (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_second,
    output logic [CW-1:0]         out_count,
    output logic                  out_short,
    output logic                  out_ovf
  );

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  state_t                  state, state_next;
  logic [CW-1:0]           count;
  logic                    ovf;
  logic [DATA_WIDTH-1:0]   trk_max, trk_second;
  logic                    accept;
  logic                    trk_clr, trk_load, trk_en;
  logic                    cnt_clr, cnt_load, cnt_inc, ovf_set;

  assign accept = in_valid && in_ready;

  max2_track #(.DATA_WIDTH(DATA_WIDTH)) u_track (
    .clk    (clk),
    .reset  (reset),
    .clr    (trk_clr),
    .load   (trk_load),
    .en     (trk_en),
    .din    (in_data),
    .max    (trk_max),
    .second (trk_second)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Flush overrides both the input beat and the result handshake.
  always_comb begin
    state_next = state;
    trk_clr    = 1'b0;
    trk_load   = 1'b0;
    trk_en     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    ovf_set    = 1'b0;
    if (flush) begin
      state_next = IDLE;
      trk_clr    = 1'b1;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            trk_load   = 1'b1;
            cnt_load   = 1'b1;
            state_next = in_last ? REPORT : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (count < MAX_CNT) begin
              trk_en  = 1'b1;
              cnt_inc = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
            if (in_last) state_next = REPORT;
          end
        end
        REPORT: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (cnt_clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (cnt_load) begin
      count <= CW'(1);
      ovf   <= 1'b0;
    end else begin
      if (cnt_inc) count <= count + CW'(1);
      if (ovf_set) ovf   <= 1'b1;
    end
  end

  assign in_ready   = (state != REPORT);
  assign out_valid  = (state == REPORT);
  assign out_max    = out_valid ? trk_max    : '0;
  assign out_second = out_valid ? trk_second : '0;
  assign out_count  = out_valid ? count      : '0;
  assign out_short  = out_valid && (count < CW'(2));
  assign out_ovf    = out_valid && ovf;

endmodule
